// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type, time-field limits and a small helper for the alarm path
//   Contents: alarm_state_t (DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3),
//   TIME_W / HRS_MAX / MIN_MAX / SEC_MAX, max_int()
package alarm_pkg;
  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZE} alarm_state_t;
  localparam int TIME_W = 8;
  localparam int HRS_MAX = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sec_countdown.sv
// sec_countdown: loadable seconds down-counter that stops at zero
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load i_load_val (wins over i_tick)
//   i_tick       : decrement request, ignored when the count is already zero
//   o_count      : current count
//   o_hit_one    : count equals one, so the next tick expires it
module sec_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic         o_hit_one
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_tick && r_count != '0) r_count <= r_count - 1'b1;
  assign o_count = r_count;
  assign o_hit_one = r_count == W'(1);
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm sequencing FSM (match, ring, snooze, stop, timeout, disarm)
//   clk, reset          : clock, asynchronous active-high reset
//   i_tick_1hz          : one-clk pulse per second
//   i_arm               : alarm enable switch
//   i_snooze_key        : snooze key level, acted on at its rising edge
//   i_stop_key          : stop key level, acted on at its rising edge
//   i_set_active        : time/alarm being set, blocks new matches
//   i_cur_hrs/min/sec   : running time
//   i_alm_hrs/min       : alarm setpoint
//   o_ring, o_snoozing  : in RINGING / in SNOOZE
//   o_ring_blink        : LED blink, toggles on each tick while ringing
//   o_state             : encoded FSM state
//   o_snooze_cnt        : snoozes used in the current event
module alarm_ctrl import alarm_pkg::*; #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick_1hz,
  input  logic              i_arm,
  input  logic              i_snooze_key,
  input  logic              i_stop_key,
  input  logic              i_set_active,
  input  logic [TIME_W-1:0] i_cur_hrs,
  input  logic [TIME_W-1:0] i_cur_min,
  input  logic [TIME_W-1:0] i_cur_sec,
  input  logic [TIME_W-1:0] i_alm_hrs,
  input  logic [TIME_W-1:0] i_alm_min,
  output logic              o_ring,
  output logic              o_ring_blink,
  output logic              o_snoozing,
  output logic [1:0]        o_state,
  output logic [1:0]        o_snooze_cnt
);
  localparam int CW = $clog2(max_int(SNOOZE_SEC, RING_TIMEOUT_SEC) + 1);
  alarm_state_t r_state, w_next;
  logic r_snooze_q, r_stop_q, r_blink, w_blink;
  logic [1:0] r_snooze_cnt, w_snooze_cnt;
  logic w_snooze_rise, w_stop_rise, w_match, w_load, w_hit_one, w_unused;
  logic [CW-1:0] w_load_val, w_count;
  assign w_snooze_rise = i_snooze_key & ~r_snooze_q;
  assign w_stop_rise = i_stop_key & ~r_stop_q;
  assign w_match = i_tick_1hz & ~i_set_active & (i_cur_hrs == i_alm_hrs) &
                   (i_cur_min == i_alm_min) & (i_cur_sec == '0);
  assign w_unused = ^w_count;
  sec_countdown #(.W(CW)) u_countdown (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (i_tick_1hz),
    .o_count    (w_count),
    .o_hit_one  (w_hit_one)
  );
  // Disarm loads zero, which also clears the countdown.
  always_comb begin
    w_next = r_state;
    w_snooze_cnt = r_snooze_cnt;
    w_load = 1'b0;
    w_load_val = '0;
    if (!i_arm) begin
      w_next = DISARMED;
      w_snooze_cnt = '0;
      w_load = 1'b1;
    end else case (r_state)
      DISARMED: w_next = ARMED;
      ARMED: if (w_match) begin
        w_next = RINGING;
        w_load = 1'b1;
        w_load_val = CW'(RING_TIMEOUT_SEC);
        w_snooze_cnt = '0;
      end
      RINGING: if (w_stop_rise) w_next = ARMED;
      else if (w_snooze_rise && r_snooze_cnt < 2'(MAX_SNOOZES)) begin
        w_next = SNOOZE;
        w_load = 1'b1;
        w_load_val = CW'(SNOOZE_SEC);
        w_snooze_cnt = r_snooze_cnt + 2'd1;
      end else if (i_tick_1hz && w_hit_one) w_next = ARMED;
      default: if (w_stop_rise) w_next = ARMED;
      else if (i_tick_1hz && w_hit_one) begin
        w_next = RINGING;
        w_load = 1'b1;
        w_load_val = CW'(RING_TIMEOUT_SEC);
      end
    endcase
    // Blink starts lit on entry to RINGING, toggles per tick, dark elsewhere.
    w_blink = (w_next != RINGING) ? 1'b0 : (r_state != RINGING) ? 1'b1 : r_blink ^ i_tick_1hz;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= DISARMED;
      r_snooze_cnt <= '0;
      r_blink <= 1'b0;
      r_snooze_q <= 1'b0;
      r_stop_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_snooze_cnt <= w_snooze_cnt;
      r_blink <= w_blink;
      r_snooze_q <= i_snooze_key;
      r_stop_q <= i_stop_key;
    end
  assign o_ring = r_state == RINGING;
  assign o_snoozing = r_state == SNOOZE;
  assign o_ring_blink = r_blink;
  assign o_state = r_state;
  assign o_snooze_cnt = r_snooze_cnt;
endmodule
